// File: rtl/afifo_rd_stream.sv
// Read-side stream adapter for the async FIFO: pops with credit, absorbs the
// one-cycle RAM latency in a small skid buffer, and flags FIFO protocol errors.
module afifo_rd_stream #(
  parameter int unsigned DW        = 24,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fifo_empty,
  input  logic          fifo_vld,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_pop,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] occ,
  output logic          err_ovf,
  output logic          err_unexp
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned SW = CW + 1;

  logic [DW-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          inflight;

  logic          deq;
  logic          full;
  logic          ovf;
  logic          wr_en;
  logic [SW-1:0] credit;

  // Credit counts stored words plus the word already requested last cycle.
  assign m_valid  = (count != '0);
  assign deq      = m_valid & m_ready;
  assign credit   = SW'(count) + SW'(inflight) - SW'(deq);
  assign fifo_pop = !rst & !fifo_empty & (credit < SW'(BUF_DEPTH));
  assign full     = (count == CW'(BUF_DEPTH));
  assign ovf      = fifo_vld & full & !deq;
  assign wr_en    = fifo_vld & !ovf;
  assign m_data   = mem_q[rd_ptr];
  assign occ      = count;

  // Buffer storage and pointers; a write and a read at full are allowed together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr] <= fifo_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Occupancy, in-flight tracking and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      inflight  <= 1'b0;
      err_ovf   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      case ({wr_en, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      inflight  <= fifo_pop;
      err_ovf   <= err_ovf | ovf;
      err_unexp <= err_unexp | (fifo_vld & !inflight);
    end
  end

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream with a behavioural FIFO read-side model.
module tb_afifo_rd_stream;

  localparam int unsigned DW = 24;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_vld;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] occ;
  logic          err_ovf;
  logic          err_unexp;

  afifo_rd_stream #(.DW(DW), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_vld(fifo_vld),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .occ(occ), .err_ovf(err_ovf),
    .err_unexp(err_unexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model state and per-cycle observation logs
  logic [DW-1:0] src[$];
  logic [DW-1:0] got[$];
  int            npop, didx, max_occ;
  bit            prev_pop, pop_viol;
  bit            pop_log[$];
  bit            mv_log[$];
  int            occ_log[$];
  logic [DW-1:0] md_log[$];

  // One clock cycle: drive inputs after the edge, observe mid-cycle.
  task automatic drive_cycle(input bit rdy, input bit allow, input bit fv, input logic [DW-1:0] fd);
    int credit;
    @(posedge clk);
    #1;
    fifo_vld  = prev_pop | fv;
    fifo_data = '0;
    if (fv) fifo_data = fd;
    else if (prev_pop) begin
      fifo_data = src[didx];
      didx++;
    end
    fifo_empty = !(allow && (npop < src.size()));
    m_ready    = rdy;
    #3;
    if (m_valid && m_ready) got.push_back(m_data);
    if (int'(occ) > max_occ) max_occ = int'(occ);
    credit = int'(occ) + int'(prev_pop) - int'(m_valid && m_ready);
    if (fifo_pop && credit >= 2) pop_viol = 1'b1;
    pop_log.push_back(fifo_pop);
    mv_log.push_back(m_valid);
    occ_log.push_back(int'(occ));
    md_log.push_back(m_data);
    if (fifo_pop) npop++;
    prev_pop = fifo_pop;
  endtask

  task automatic init_model();
    int guard;
    guard = 0;
    while ((prev_pop || occ != '0) && guard < 20) begin
      drive_cycle(1'b1, 1'b0, 1'b0, '0);
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin n_err++; $display("FAIL drain_timeout occ=%0d required=0", occ); end
    src.delete(); got.delete(); pop_log.delete(); mv_log.delete(); occ_log.delete(); md_log.delete();
    npop = 0; didx = 0; max_occ = 0; pop_viol = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_empty = 1'b0; m_ready = 1'b1; fifo_vld = 1'b0; fifo_data = '0;
    repeat (3) begin
      @(posedge clk); #4;
      n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL rst_pop got=%b exp=0", fifo_pop); end
      n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_mvalid got=%b exp=0", m_valid); end
      n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL rst_occ got=%0d exp=0", occ); end
      n_cmp++; if ({err_ovf, err_unexp} !== 2'b00) begin n_err++; $display("FAIL rst_err got=%b%b exp=00", err_ovf, err_unexp); end
      n_cmp++; if (m_data !== 24'h0) begin n_err++; $display("FAIL rst_mdata got=%h exp=000000", m_data); end
    end
    @(posedge clk); #1; rst = 1'b0; #3;
    n_cmp++; if (fifo_pop !== 1'b1) begin n_err++; $display("FAIL rst_first_pop got=%b exp=1", fifo_pop); end
    // Reset again with the popped word in flight; FIFO side resets too.
    @(posedge clk); #1; rst = 1'b1; fifo_empty = 1'b1; #3;
    n_cmp++; if (fifo_pop !== 1'b0) begin n_err++; $display("FAIL rst_mid_pop got=%b exp=0", fifo_pop); end
    @(posedge clk); #1; rst = 1'b0;
    prev_pop = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (occ !== 2'd0) begin n_err++; $display("FAIL rst_mid_occ got=%0d exp=0", occ); end
    n_cmp++; if (err_unexp !== 1'b0) begin n_err++; $display("FAIL rst_mid_unexp got=%b exp=0", err_unexp); end
  endtask

  task automatic test_single();
    init_model();
    src.push_back(24'hABCDEF);
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, '0);
    n_cmp++; if ({pop_log[0], pop_log[1]} !== 2'b10) begin n_err++; $display("FAIL single_pop got=%b%b exp=10", pop_log[0], pop_log[1]); end
    n_cmp++; if ({mv_log[1], mv_log[2], mv_log[3]} !== 3'b010) begin n_err++; $display("FAIL single_mvalid got=%b%b%b exp=010", mv_log[1], mv_log[2], mv_log[3]); end
    n_cmp++; if (md_log[2] !== 24'hABCDEF) begin n_err++; $display("FAIL single_data got=%h exp=abcdef", md_log[2]); end
    n_cmp++; if (occ_log[3] !== 0) begin n_err++; $display("FAIL single_occ got=%0d exp=0", occ_log[3]); end
    n_cmp++; if (got.size() !== 1) begin n_err++; $display("FAIL single_beats got=%0d exp=1", got.size()); end
  endtask

  task automatic test_stream();
    int pops, beats;
    init_model();
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    repeat (12) drive_cycle(1'b1, 1'b1, 1'b0, '0);
    pops = 0; beats = 0;
    for (int c = 0; c < 8; c++) pops += int'(pop_log[c]);
    for (int c = 2; c < 10; c++) beats += int'(mv_log[c]);
    n_cmp++; if (pops !== 8) begin n_err++; $display("FAIL stream_pops got=%0d exp=8", pops); end
    n_cmp++; if (beats !== 8 || mv_log[1] !== 1'b0 || mv_log[10] !== 1'b0) begin n_err++; $display("FAIL stream_gaps got=%0d exp=8", beats); end
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== DW'(i + 1)) begin n_err++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got[i], DW'(i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_md;
    init_model();
    for (int i = 0; i < 8; i++) src.push_back(DW'(24'h000010 + i));
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, '0);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, '0);
    exp_md = src[got.size()];
    n_cmp++; if (occ_log[8] !== 2) begin n_err++; $display("FAIL bp_occ got=%0d exp=2", occ_log[8]); end
    n_cmp++; if ({pop_log[6], pop_log[7], pop_log[8]} !== 3'b000) begin n_err++; $display("FAIL bp_pop got=%b%b%b exp=000", pop_log[6], pop_log[7], pop_log[8]); end
    n_cmp++; if (npop !== got.size() + 2) begin n_err++; $display("FAIL bp_captured got=%0d exp=%0d", npop, got.size() + 2); end
    for (int c = 6; c < 9; c++) begin
      n_cmp++; if (md_log[c] !== exp_md) begin n_err++; $display("FAIL bp_hold[%0d] got=%h exp=%h", c, md_log[c], exp_md); end
    end
    repeat (14) drive_cycle(1'b1, 1'b1, 1'b0, '0);
    n_cmp++; if (got.size() !== 8) begin n_err++; $display("FAIL bp_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== DW'(24'h000010 + i)) begin n_err++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got[i], DW'(24'h000010 + i)); end
    end
    n_cmp++; if (err_ovf !== 1'b0) begin n_err++; $display("FAIL bp_err_ovf got=%b exp=0", err_ovf); end
  endtask

  task automatic test_ready_toggle();
    init_model();
    for (int i = 0; i < 16; i++) src.push_back(DW'(24'h5A0000 + i * 3));
    for (int c = 0; c < 50; c++) drive_cycle(c % 2 == 0, 1'b1, 1'b0, '0);
    n_cmp++; if (got.size() !== 16) begin n_err++; $display("FAIL tog_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== DW'(24'h5A0000 + i * 3)) begin n_err++; $display("FAIL tog_data[%0d] got=%h exp=%h", i, got[i], DW'(24'h5A0000 + i * 3)); end
    end
    n_cmp++; if (max_occ > 2) begin n_err++; $display("FAIL tog_max_occ got=%0d exp<=2", max_occ); end
    n_cmp++; if (pop_viol !== 1'b0) begin n_err++; $display("FAIL tog_pop_credit got=%b exp=0", pop_viol); end
  endtask

  task automatic test_errors();
    init_model();
    n_cmp++; if ({err_ovf, err_unexp} !== 2'b00) begin n_err++; $display("FAIL err_pre got=%b%b exp=00", err_ovf, err_unexp); end
    drive_cycle(1'b0, 1'b0, 1'b1, 24'hA1A1A1);
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (err_unexp !== 1'b1) begin n_err++; $display("FAIL err_unexp got=%b exp=1", err_unexp); end
    n_cmp++; if (occ !== 2'd1) begin n_err++; $display("FAIL err_unexp_stored got=%0d exp=1", occ); end
    drive_cycle(1'b0, 1'b0, 1'b1, 24'hA2A2A2);
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (err_ovf !== 1'b0 || occ !== 2'd2) begin n_err++; $display("FAIL err_fill ovf=%b occ=%0d exp ovf=0 occ=2", err_ovf, occ); end
    drive_cycle(1'b0, 1'b0, 1'b1, 24'hA3A3A3);
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (err_ovf !== 1'b1) begin n_err++; $display("FAIL err_ovf got=%b exp=1", err_ovf); end
    n_cmp++; if (occ !== 2'd2) begin n_err++; $display("FAIL err_ovf_occ got=%0d exp=2", occ); end
    n_cmp++; if (m_data !== 24'hA1A1A1) begin n_err++; $display("FAIL err_ovf_head got=%h exp=a1a1a1", m_data); end
    repeat (4) drive_cycle(1'b1, 1'b0, 1'b0, '0);
    n_cmp++; if (got.size() !== 2) begin n_err++; $display("FAIL err_drain_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      n_cmp++; if (got[0] !== 24'hA1A1A1 || got[1] !== 24'hA2A2A2) begin n_err++; $display("FAIL err_drain_data got=%h,%h exp=a1a1a1,a2a2a2", got[0], got[1]); end
    end
    n_cmp++; if ({err_ovf, err_unexp} !== 2'b11) begin n_err++; $display("FAIL err_sticky got=%b%b exp=11", err_ovf, err_unexp); end
    @(posedge clk); #1; rst = 1'b1; #3;
    n_cmp++; if ({err_ovf, err_unexp} !== 2'b00) begin n_err++; $display("FAIL err_clear got=%b%b exp=00", err_ovf, err_unexp); end
    @(posedge clk); #1; rst = 1'b0;
    prev_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_vld = 1'b0; fifo_data = '0; m_ready = 1'b0;
    npop = 0; didx = 0; max_occ = 0; prev_pop = 1'b0; pop_viol = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_ready_toggle();
    test_errors();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout compared=%0d required=finish", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/afifo_rd_stream.md
Name: afifo_rd_stream

Overview:
- Sits directly downstream of the async FIFO read side, in the read clock domain.
- Issues pop to the FIFO and absorbs its one-clock RAM read latency (vld/data_out arrive the cycle after pop).
- Presents the data on a valid/ready stream with a small skid buffer, sustaining one word per cycle under backpressure with no loss or duplication.
- Flags protocol violations on the FIFO side with sticky error bits.

Parameters:
- DW, 24, data width; must match the FIFO DW.
- BUF_DEPTH, 2, skid-buffer entries; power of two, minimum 2.
- CW, $clog2(BUF_DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  read-domain clock; same clock as the FIFO rclk.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_vld  input  1  FIFO read-data valid; asserted the cycle after fifo_pop.
- fifo_data  input  DW  FIFO read data; qualified by fifo_vld.
- fifo_pop  output  1  pop request to the FIFO.
- m_valid  output  1  output stream valid.
- m_ready  input  1  output stream ready.
- m_data  output  DW  output stream data.
- occ  output  CW  current skid-buffer occupancy.
- err_ovf  output  1  sticky: fifo_vld arrived while the buffer was full and not draining.
- err_unexp  output  1  sticky: fifo_vld arrived with no pop issued the previous cycle.

Behaviour:
- Reset (asynchronous, active-high):
  - Values: count=0, wr_ptr=0, rd_ptr=0, inflight=0, err_ovf=0, err_unexp=0.
  - Outputs: fifo_pop=0, m_valid=0, occ=0, m_data=0; buffer storage also cleared.
- Internal state:
  - Circular buffer of BUF_DEPTH x DW.
  - wr_ptr and rd_ptr of log2(BUF_DEPTH) bits, wrapping naturally.
  - count of CW bits.
  - inflight: register, equal to fifo_pop of the previous cycle.
- deq = m_valid & m_ready.
- fifo_pop = !fifo_empty & ((count + inflight - deq) < BUF_DEPTH).
  - Arithmetic is done at CW+1 bits.
  - Combinational from m_ready and fifo_empty; no other combinational inputs.
- Write: on fifo_vld, store fifo_data at wr_ptr and increment wr_ptr, except in the overflow case below.
- Overflow:
  - Condition: fifo_vld & count==BUF_DEPTH & !deq.
  - Effect: data dropped, wr_ptr/count unchanged, err_ovf set next cycle.
- Unexpected data:
  - Condition: fifo_vld & !inflight.
  - Effect: err_unexp set next cycle; the data is still stored if space allows.
- Read side:
  - m_valid = (count != 0), registered state only; it never depends on m_ready.
  - m_data = buf[rd_ptr].
  - On deq, increment rd_ptr.
- count update:
  - +1 on an accepted write only.
  - -1 on deq only.
  - Unchanged on both together.
  - Simultaneous write and deq at count==BUF_DEPTH is legal: no overflow, count stays BUF_DEPTH.
- Hold rule: m_data and m_valid stay stable while m_valid & !m_ready.
- Latency: pop in cycle N → fifo_vld in N+1 → m_valid in N+2 (no bypass path).
- Throughput: steady state with m_ready=1 gives count=1, inflight=1, one pop and one deq per cycle.
- Backpressure: with m_ready=0, at most BUF_DEPTH words are buffered or in flight; fifo_pop is then held 0.
- FIFO empty: fifo_pop is never asserted while fifo_empty=1, even if credit is available.
- Reset mid-operation:
  - The buffer and an in-flight word are discarded.
  - The FIFO read side must be reset in the same cycle (common reset source); no recovery logic for a one-sided reset.
- Error bits: err_ovf and err_unexp clear only on rst.

Test Plan:
- Reset: assert rst with fifo_empty=0 and m_ready=1 → fifo_pop=0, m_valid=0, occ=0, err_ovf=0, err_unexp=0 throughout reset; first fifo_pop one cycle after release.
- Single word: fifo_empty low for one cycle with data 0xABCDEF, m_ready=1 → fifo_pop in cycle 0, fifo_vld in cycle 1, m_valid=1 with m_data=0xABCDEF in cycle 2 only, occ back to 0 in cycle 3.
- Streaming: 8 words 0x000001..0x000008, fifo_empty low, m_ready=1 → 8 consecutive fifo_pop cycles, 8 consecutive m_valid beats in order, no gaps.
- Backpressure: m_ready=0 during streaming → exactly 2 words captured, occ=2, fifo_pop=0, m_data constant. After m_ready=1, the remaining words follow in order with no loss or duplicates, and err_ovf stays 0.
- Ready toggling: m_ready pattern 1,0,1,0... over 16 words → output order matches input, occ never exceeds 2, and fifo_pop never asserted when occ + inflight - deq = 2.
- Errors:
  - fifo_vld pulse with no prior pop → err_unexp=1 next cycle, held until rst.
  - Forced fifo_vld at occ=2 with m_ready=0 → err_ovf=1, occ stays 2, stored data unchanged.
